// File: rtl/exp_pkg.sv
// Shared helpers for the streaming exp unit: ROM entry generator,
// saturating adder and parameter legality check.
package exp_pkg;

  // k is the raw input code; it is reinterpreted as a signed in_w-bit value.
  function automatic int exp_q(int k, int in_w, int in_frac, int out_w, int out_frac);
    int  k_s;
    int  max_v;
    real v;
    k_s   = (k >= (1 << (in_w - 1))) ? k - (1 << in_w) : k;
    max_v = (1 << out_w) - 1;
    v     = $floor($exp(real'(k_s) / real'(1 << in_frac)) * real'(1 << out_frac) + 0.5);
    if (v > real'(max_v)) return max_v;
    return int'(v);
  endfunction

  function automatic logic [63:0] sat_add(logic [63:0] a, logic [63:0] b, int w);
    logic [63:0] s;
    logic [63:0] max_v;
    max_v = (64'd1 << w) - 64'd1;
    s     = a + b;
    return (s > max_v) ? max_v : s;
  endfunction

  function automatic bit params_ok(int in_w, int in_frac, int out_w, int out_frac, int acc_w);
    return (in_w >= 4) && (in_w <= 10) && (in_frac >= 0) && (in_frac < in_w) &&
           (out_w >= 4) && (out_w <= 16) && (out_frac >= 0) && (out_frac <= out_w) &&
           (acc_w >= out_w) && (acc_w <= 62);
  endfunction

endpackage

// File: rtl/exp_stream_rom.sv
// Combinational exp lookup table, 2^IN_W entries, all contents fixed at elaboration.
module exp_rom
  import exp_pkg::*;
#(
  parameter int IN_W     = 6,
  parameter int IN_FRAC  = 3,
  parameter int OUT_W    = 8,
  parameter int OUT_FRAC = 4
) (
  input  logic [IN_W-1:0]  addr_i,
  output logic [OUT_W-1:0] data_o
);

  logic [OUT_W-1:0] rom [2**IN_W];

  for (genvar k = 0; k < 2**IN_W; k++) begin : g_rom
    assign rom[k] = OUT_W'(exp_q(k, IN_W, IN_FRAC, OUT_W, OUT_FRAC));
  end

  assign data_o = rom[addr_i];

endmodule

// File: rtl/exp_stream.sv
// Two-stage valid/ready exp pipeline (S1 holds x, S2 holds ROM[x]) with a
// saturating per-frame output sum pulsed out on the last sample of each frame.
module exp_stream
  import exp_pkg::*;
#(
  parameter int IN_W     = 6,
  parameter int IN_FRAC  = 3,
  parameter int OUT_W    = 8,
  parameter int OUT_FRAC = 4,
  parameter int ACC_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             sum_valid,
  output logic [ACC_W-1:0] sum_data
);

  if (!params_ok(IN_W, IN_FRAC, OUT_W, OUT_FRAC, ACC_W)) begin : g_bad_params
    $error("exp_stream: illegal parameter combination");
  end

  logic             s1_vld_q;
  logic [IN_W-1:0]  s1_x_q;
  logic             s1_last_q;
  logic             s2_vld_q;
  logic [OUT_W-1:0] s2_dat_q;
  logic             s2_last_q;
  logic [OUT_W-1:0] rom_dat;
  logic             s1_adv, s2_adv, in_fire, out_fire;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             sum_vld_q, sum_vld_d;
  logic [ACC_W-1:0] acc_plus;

  // A stage may load whenever its own slot frees up this cycle.
  assign s2_adv   = !s2_vld_q || out_ready;
  assign s1_adv   = !s1_vld_q || s2_adv;
  assign in_ready = s1_adv;
  assign in_fire  = in_valid && s1_adv;
  assign out_fire = s2_vld_q && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_x_q    <= '0;
      s1_last_q <= 1'b0;
    end else if (s1_adv) begin
      s1_vld_q <= in_valid;
      if (in_fire) begin
        s1_x_q    <= in_data;
        s1_last_q <= in_last;
      end
    end
  end

  exp_rom #(
    .IN_W     (IN_W),
    .IN_FRAC  (IN_FRAC),
    .OUT_W    (OUT_W),
    .OUT_FRAC (OUT_FRAC)
  ) u_rom (
    .addr_i (s1_x_q),
    .data_o (rom_dat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld_q  <= 1'b0;
      s2_dat_q  <= '0;
      s2_last_q <= 1'b0;
    end else if (s2_adv) begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_dat_q  <= rom_dat;
        s2_last_q <= s1_last_q;
      end
    end
  end

  assign out_valid = s2_vld_q;
  assign out_data  = s2_dat_q;
  assign out_last  = s2_last_q;

  assign acc_plus = ACC_W'(sat_add(64'(acc_q), 64'(s2_dat_q), ACC_W));

  always_comb begin
    acc_d     = acc_q;
    sum_d     = sum_q;
    sum_vld_d = 1'b0;
    if (out_fire) begin
      if (s2_last_q) begin
        sum_d     = acc_plus;
        sum_vld_d = 1'b1;
        acc_d     = '0;
      end else begin
        acc_d = acc_plus;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      sum_q     <= '0;
      sum_vld_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      sum_q     <= sum_d;
      sum_vld_q <= sum_vld_d;
    end
  end

  assign sum_valid = sum_vld_q;
  assign sum_data  = sum_q;

endmodule

// File: tb/tb_exp_stream.sv
// Directed self-checking bench for exp_stream with default parameters.
module tb_exp_stream;

  localparam int IN_W     = 6;
  localparam int IN_FRAC  = 3;
  localparam int OUT_W    = 8;
  localparam int OUT_FRAC = 4;
  localparam int ACC_W    = 16;
  localparam int ACC_MAX  = 65535;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_data = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [OUT_W-1:0] out_data;
  logic             out_last;
  logic             sum_valid;
  logic [ACC_W-1:0] sum_data;

  int n_checks = 0;
  int n_fail   = 0;
  int sum_pulses = 0;

  int vec[$];
  bit lst[$];
  int expv[$];

  exp_stream #(
    .IN_W(IN_W), .IN_FRAC(IN_FRAC), .OUT_W(OUT_W), .OUT_FRAC(OUT_FRAC), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .sum_valid(sum_valid), .sum_data(sum_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (sum_valid === 1'b1) sum_pulses++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Independent reference: round-half-up of exp(x/8)*16, clamped to 8 bits.
  function automatic int model_exp(int x);
    real v;
    v = $floor($exp(real'(x) / 8.0) * 16.0 + 0.5);
    if (v > 255.0) return 255;
    return int'(v);
  endfunction

  // Streams vec[] back-to-back with out_ready=1; call right after a negedge
  // with an empty pipeline. Sample presented in cycle c is visible in c+2.
  task automatic run_stream(input string tag);
    int n, acc, j;
    int es[$];
    n   = vec.size();
    acc = 0;
    out_ready = 1'b1;
    for (int i = 0; i < n + 2; i++) begin
      in_valid = (i < n);
      in_data  = (i < n) ? IN_W'(vec[i]) : '0;
      in_last  = (i < n) ? lst[i] : 1'b0;
      @(posedge clk);
      @(negedge clk);
      if (i == 0) chk({tag, "/latency_not_early"}, 64'(out_valid), 64'd0);
      if (i >= 1 && i - 1 < n) begin
        j = i - 1;
        chk($sformatf("%s/valid[%0d]", tag, j), 64'(out_valid), 64'd1);
        chk($sformatf("%s/data[%0d]", tag, j), 64'(out_data), 64'(expv[j]));
        chk($sformatf("%s/last[%0d]", tag, j), 64'(out_last), 64'(lst[j]));
        acc = acc + expv[j];
        if (acc > ACC_MAX) acc = ACC_MAX;
        es.push_back(acc);
        if (lst[j]) acc = 0;
      end
      if (i >= 2 && i - 2 < n) begin
        j = i - 2;
        chk($sformatf("%s/sum_valid[%0d]", tag, j), 64'(sum_valid), 64'(lst[j]));
        if (lst[j]) chk($sformatf("%s/sum_data[%0d]", tag, j), 64'(sum_data), 64'(es[j]));
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    int p0, sent, got, prev_data;
    bit stall_prev;
    int q[$];
    int rv[10];

    // Reset state
    #2;
    chk("rst/in_ready", 64'(in_ready), 64'd1);
    chk("rst/out_valid", 64'(out_valid), 64'd0);
    chk("rst/out_data", 64'(out_data), 64'd0);
    chk("rst/out_last", 64'(out_last), 64'd0);
    chk("rst/sum_valid", 64'(sum_valid), 64'd0);
    chk("rst/sum_data", 64'(sum_data), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors with hand-computed results; last on the final one
    vec  = '{0, 8, 16, 22, 23, -32};
    lst  = '{0, 0, 0, 0, 0, 1};
    expv = '{16, 43, 118, 250, 255, 0};
    run_stream("vec");
    chk("vec/frame_sum_682", 64'(sum_data), 64'd682);

    // Full code sweep against the reference model
    vec.delete(); lst.delete(); expv.delete();
    for (int k = 0; k < 64; k++) begin
      vec.push_back(k >= 32 ? k - 64 : k);
      lst.push_back(k == 63);
      expv.push_back(model_exp(k >= 32 ? k - 64 : k));
    end
    run_stream("sweep");

    // Frame {0,8,16} then a one-sample frame {0}
    p0   = sum_pulses;
    vec  = '{0, 8, 16, 0};
    lst  = '{0, 0, 1, 1};
    expv = '{16, 43, 118, 16};
    run_stream("frame");
    chk("frame/pulse_count", 64'(sum_pulses - p0), 64'd2);
    repeat (3) @(negedge clk);
    chk("frame/sum_hold_16", 64'(sum_data), 64'd16);
    chk("frame/no_extra_pulse", 64'(sum_valid), 64'd0);

    // Random backpressure stream
    rv = '{3, -5, 20, 0, 8, -32, 23, 12, -1, 16};
    sent = 0; got = 0; stall_prev = 0; prev_data = 0;
    for (int cyc = 0; cyc < 300 && got < 10; cyc++) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (sent < 10);
      in_data   = IN_W'(rv[sent % 10]);
      in_last   = (sent == 9);
      #1;
      if (stall_prev) begin
        chk("bp/stall_valid", 64'(out_valid), 64'd1);
        chk("bp/stall_data", 64'(out_data), 64'(prev_data));
      end
      chk("bp/in_ready", 64'(in_ready), 64'(!(q.size() == 2 && !out_ready)));
      if (out_valid && out_ready) begin
        chk($sformatf("bp/data[%0d]", got), 64'(out_data), 64'(q[0]));
        chk($sformatf("bp/last[%0d]", got), 64'(out_last), 64'(got == 9));
        void'(q.pop_front());
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model_exp(rv[sent]));
        sent++;
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = int'(out_data);
    end
    chk("bp/all_received", 64'(got), 64'd10);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("bp/drained", 64'(out_valid), 64'd0);

    // Saturating frame sum: 300 x 255 clamps at 65535
    vec.delete(); lst.delete(); expv.delete();
    for (int k = 0; k < 300; k++) begin
      vec.push_back(23);
      lst.push_back(k == 299);
      expv.push_back(255);
    end
    run_stream("sat");
    chk("sat/sum_65535", 64'(sum_data), 64'd65535);

    // Reset mid-frame with a partial sum and two samples in flight
    vec = '{0}; lst = '{0}; expv = '{16};
    run_stream("pre_rst");
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = IN_W'(8); in_last = 1'b0;
    @(posedge clk); @(negedge clk);
    in_data = IN_W'(16);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("full/in_ready_low", 64'(in_ready), 64'd0);
    chk("full/out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    #1;
    chk("full/in_ready_follows_out_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b0;
    p0 = sum_pulses;
    rst_n = 1'b0;
    #1;
    chk("mid_rst/out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst/out_data", 64'(out_data), 64'd0);
    chk("mid_rst/out_last", 64'(out_last), 64'd0);
    chk("mid_rst/in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst/sum_valid", 64'(sum_valid), 64'd0);
    chk("mid_rst/sum_data", 64'(sum_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst/no_pulse", 64'(sum_pulses - p0), 64'd0);
    vec = '{8}; lst = '{1}; expv = '{43};
    run_stream("post_rst");
    chk("post_rst/sum_from_zero", 64'(sum_data), 64'd43);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
